i_cache: RTL and testbench

- Direct-mapped, read-only instruction cache between the pipelined CPU instruction-fetch port (readM1/address1/data1) and a multi-cycle line-fill memory.
- Serves hits combinationally in the request cycle.
- On a miss, stalls the CPU via cpu_ready=0, fetches one aligned 4-word line, installs it, then serves the hit.
- Keeps hit/miss counters for CPI measurement.

---
 rtl/i_cache_pkg.sv | 30 +++
 rtl/i_cache_line_array.sv | 44 ++++
 rtl/i_cache.sv | 91 +++++++++
 tb/tb_i_cache.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i_cache_pkg.sv
// Shared geometry, address-field helpers and FSM encoding for the
// direct-mapped instruction cache.
package i_cache_pkg;

    localparam int unsigned WORD_SIZE   = 16;
    localparam int unsigned LINE_WORDS  = 4;
    localparam int unsigned NUM_LINES   = 4;
    localparam int unsigned TAG_BITS    = 12;
    localparam int unsigned INDEX_BITS  = 2;
    localparam int unsigned OFFSET_BITS = 2;
    localparam int unsigned LINE_BITS   = WORD_SIZE * LINE_WORDS;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    function automatic logic [TAG_BITS-1:0] addr_tag(input logic [WORD_SIZE-1:0] a);
        return a[WORD_SIZE-1 -: TAG_BITS];
    endfunction

    function automatic logic [INDEX_BITS-1:0] addr_index(input logic [WORD_SIZE-1:0] a);
        return a[OFFSET_BITS +: INDEX_BITS];
    endfunction

    function automatic logic [OFFSET_BITS-1:0] addr_offset(input logic [WORD_SIZE-1:0] a);
        return a[OFFSET_BITS-1:0];
    endfunction

endpackage

// File: rtl/i_cache_line_array.sv
// Valid/tag/data storage for the cache: one combinational read port,
// one write port, and a flush-all that clears every valid bit.
module cache_line_array
    import i_cache_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_flush,
    input  logic [INDEX_BITS-1:0] i_rd_index,
    output logic                  o_rd_valid,
    output logic [TAG_BITS-1:0]   o_rd_tag,
    output logic [LINE_BITS-1:0]  o_rd_line,
    input  logic                  i_wr_en,
    input  logic [INDEX_BITS-1:0] i_wr_index,
    input  logic [TAG_BITS-1:0]   i_wr_tag,
    input  logic [LINE_BITS-1:0]  i_wr_line
);

    logic [NUM_LINES-1:0] r_valid;
    logic [TAG_BITS-1:0]  r_tag  [NUM_LINES];
    logic [LINE_BITS-1:0] r_data [NUM_LINES];

    // Valid bits: reset and flush clear all lines; a fill marks its line valid.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_index] <= 1'b1;
        end
    end

    // Tag and data arrays are left unreset; only the valid bits qualify them.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_tag[i_wr_index]  <= i_wr_tag;
            r_data[i_wr_index] <= i_wr_line;
        end
    end

    assign o_rd_valid = r_valid[i_rd_index];
    assign o_rd_tag   = r_tag[i_rd_index];
    assign o_rd_line  = r_data[i_rd_index];

endmodule

// File: rtl/i_cache.sv
// Direct-mapped read-only instruction cache: combinational hits, stalling
// line fills from a multi-cycle memory, and hit/miss counters.
module i_cache
    import i_cache_pkg::*;
(
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 cpu_read,
    input  logic [WORD_SIZE-1:0] cpu_address,
    output logic [WORD_SIZE-1:0] cpu_data,
    output logic                 cpu_ready,
    input  logic                 cpu_flush,
    output logic                 mem_read,
    output logic [WORD_SIZE-1:0] mem_address,
    input  logic [LINE_BITS-1:0] mem_data,
    input  logic                 mem_valid,
    output logic [WORD_SIZE-1:0] hit_count,
    output logic [WORD_SIZE-1:0] miss_count
);

    state_t r_state;
    logic   r_drop_fill;

    logic                   w_rd_valid;
    logic [TAG_BITS-1:0]    w_rd_tag;
    logic [LINE_BITS-1:0]   w_rd_line;
    logic                   w_hit;
    logic                   w_wr_en;
    logic [OFFSET_BITS-1:0] w_offset;

    // mem_address holds the captured miss address for the whole fill.
    // A flush in the same cycle as mem_valid also discards the incoming line.
    assign w_wr_en = (r_state == FILL) && mem_valid && !r_drop_fill && !cpu_flush && !Reset;

    cache_line_array u_lines (
        .i_clk      (Clk),
        .i_rst      (Reset),
        .i_flush    (cpu_flush),
        .i_rd_index (addr_index(cpu_address)),
        .o_rd_valid (w_rd_valid),
        .o_rd_tag   (w_rd_tag),
        .o_rd_line  (w_rd_line),
        .i_wr_en    (w_wr_en),
        .i_wr_index (addr_index(mem_address)),
        .i_wr_tag   (addr_tag(mem_address)),
        .i_wr_line  (mem_data)
    );

    assign w_offset  = addr_offset(cpu_address);
    assign w_hit     = cpu_read && w_rd_valid && (w_rd_tag == addr_tag(cpu_address)) && (r_state == IDLE);
    assign cpu_ready = w_hit;
    assign cpu_data  = w_hit ? w_rd_line[32'(w_offset) * WORD_SIZE +: WORD_SIZE] : '0;

    // Fill FSM with registered memory request and hit/miss counters.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= IDLE;
            r_drop_fill <= 1'b0;
            mem_read    <= 1'b0;
            mem_address <= '0;
            hit_count   <= '0;
            miss_count  <= '0;
        end else begin
            if (w_hit) begin
                hit_count <= hit_count + 1'b1;
            end
            unique case (r_state)
                IDLE: begin
                    if (cpu_read && !w_hit && !cpu_flush) begin
                        mem_address <= {cpu_address[WORD_SIZE-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                        mem_read    <= 1'b1;
                        miss_count  <= miss_count + 1'b1;
                        r_state     <= FILL;
                    end
                end
                FILL: begin
                    if (cpu_flush) begin
                        r_drop_fill <= 1'b1;
                    end
                    if (mem_valid) begin
                        mem_read    <= 1'b0;
                        r_drop_fill <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i_cache.sv
// Directed scoreboard bench for i_cache: expected fetch words and fill
// addresses are queued when a request is driven and popped on DUT response.
module tb_i_cache;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        cpu_read;
    logic [15:0] cpu_address;
    logic [15:0] cpu_data;
    logic        cpu_ready;
    logic        cpu_flush;
    logic        mem_read;
    logic [15:0] mem_address;
    logic [63:0] mem_data;
    logic        mem_valid;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] exp_data_q[$];
    logic [15:0] exp_addr_q[$];
    logic [15:0] exp_hits = 16'h0;
    logic [15:0] exp_miss = 16'h0;

    i_cache dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .cpu_read    (cpu_read),
        .cpu_address (cpu_address),
        .cpu_data    (cpu_data),
        .cpu_ready   (cpu_ready),
        .cpu_flush   (cpu_flush),
        .mem_read    (mem_read),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_valid   (mem_valid),
        .hit_count   (hit_count),
        .miss_count  (miss_count)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Backing memory contents: the line at 0x0020 holds 0x1111..0x4444.
    function automatic logic [15:0] model_word(input logic [15:0] a);
        logic [15:0] off;
        off = {14'd0, a[1:0]};
        if (a[15:2] == 14'h0008) return 16'h1111 * (off + 16'd1);
        return (a * 16'h0101) ^ 16'h5A5A;
    endfunction

    function automatic logic [63:0] model_line(input logic [15:0] a);
        logic [63:0] l;
        for (int k = 0; k < 4; k++) begin
            l[16*k +: 16] = model_word({a[15:2], 2'(k)});
        end
        return l;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // One CPU fetch; answers a fill after 'lat' cycles of mem_read.
    task automatic fetch(input logic [15:0] a, input int lat, input bit miss);
        int  cyc;
        int  waited;
        bit  got;
        bit  seen;
        bit  sent;
        logic [15:0] ea;
        exp_data_q.push_back(model_word(a));
        if (miss) begin
            exp_addr_q.push_back({a[15:2], 2'b00});
            exp_miss = exp_miss + 16'd1;
        end
        cpu_read = 1'b1;
        cpu_address = a;
        cyc = 0; waited = 0; got = 0; seen = 0; sent = 0;
        while (!got && cyc < 40) begin
            @(negedge Clk);
            if (cpu_ready) begin
                chk("data", cpu_data, exp_data_q.pop_front());
                chk("mem_read_on_hit", mem_read, 1'b0);
                chk("penalty", cyc, miss ? lat + 1 : 0);
                got = 1;
            end else if (mem_read) begin
                if (!seen) begin
                    seen = 1;
                    ea = (exp_addr_q.size() > 0) ? exp_addr_q.pop_front() : 16'hxxxx;
                    chk("mem_address", mem_address, ea);
                    chk("data_stalled", cpu_data, 16'h0);
                end
                waited++;
                if (waited == lat && !sent) begin
                    mem_valid = 1'b1;
                    mem_data = model_line(mem_address);
                    sent = 1;
                end
            end
            @(posedge Clk);
            #1;
            mem_valid = 1'b0;
            cyc++;
        end
        chk("fetch_done", got, 1'b1);
        exp_hits = exp_hits + 16'd1;
        chk("hit_count", hit_count, exp_hits);
        chk("miss_count", miss_count, exp_miss);
    endtask

    initial begin
        Reset = 1'b1;
        cpu_read = 1'b1;
        cpu_address = 16'h0023;
        cpu_flush = 1'b0;
        mem_valid = 1'b0;
        mem_data = '0;
        tick();
        tick();
        @(negedge Clk);
        chk("rst_ready", cpu_ready, 1'b0);
        chk("rst_data", cpu_data, 16'h0);
        chk("rst_mem_read", mem_read, 1'b0);
        chk("rst_mem_address", mem_address, 16'h0);
        chk("rst_hits", hit_count, 16'h0);
        chk("rst_misses", miss_count, 16'h0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;

        // First miss and fill, memory answers in the third fill cycle.
        fetch(16'h0023, 3, 1'b1);

        // Sequential hits over the resident line.
        for (int i = 0; i < 4; i++) fetch(16'h0020 + 16'(i), 0, 1'b0);
        cpu_read = 1'b0;
        @(negedge Clk);
        chk("idle_ready", cpu_ready, 1'b0);
        chk("idle_mem_read", mem_read, 1'b0);
        @(posedge Clk);
        #1;
        chk("idle_hits", hit_count, exp_hits);

        // Conflict on index 0.
        fetch(16'h0060, 3, 1'b1);
        fetch(16'h0020, 3, 1'b1);
        chk("conflict_misses", miss_count, 16'd3);

        // Flush in IDLE with a hit: pre-flush array still serves, then misses.
        cpu_flush = 1'b1;
        fetch(16'h0021, 0, 1'b0);
        cpu_flush = 1'b0;
        fetch(16'h0021, 2, 1'b1);

        // Flush in IDLE with a miss: no fill starts that cycle.
        cpu_read = 1'b1;
        cpu_address = 16'h0033;
        cpu_flush = 1'b1;
        @(negedge Clk);
        chk("flush_miss_ready", cpu_ready, 1'b0);
        @(posedge Clk);
        #1;
        cpu_flush = 1'b0;
        cpu_read = 1'b0;
        @(negedge Clk);
        chk("flush_miss_no_fill", mem_read, 1'b0);
        chk("flush_miss_count", miss_count, exp_miss);
        @(posedge Clk);
        #1;
        fetch(16'h0033, 1, 1'b1);

        // Flush while filling 0x0040: the returned line is discarded.
        exp_addr_q.push_back(16'h0040);
        exp_miss = exp_miss + 16'd1;
        cpu_read = 1'b1;
        cpu_address = 16'h0040;
        tick();
        @(negedge Clk);
        chk("fill_mem_read", mem_read, 1'b1);
        chk("fill_mem_address", mem_address, exp_addr_q.pop_front());
        @(posedge Clk);
        #1;
        cpu_flush = 1'b1;
        tick();
        cpu_flush = 1'b0;
        mem_valid = 1'b1;
        mem_data = model_line(16'h0040);
        tick();
        mem_valid = 1'b0;
        cpu_read = 1'b0;
        @(negedge Clk);
        chk("drop_back_idle", mem_read, 1'b0);
        @(posedge Clk);
        #1;
        fetch(16'h0040, 2, 1'b1);

        // Reset one cycle after mem_read rises; stale mem_valid afterwards.
        cpu_read = 1'b1;
        cpu_address = 16'h0050;
        tick();
        tick();
        Reset = 1'b1;
        cpu_read = 1'b0;
        tick();
        Reset = 1'b0;
        exp_hits = 16'h0;
        exp_miss = 16'h0;
        @(negedge Clk);
        chk("midfill_rst_mem_read", mem_read, 1'b0);
        chk("midfill_rst_hits", hit_count, 16'h0);
        chk("midfill_rst_misses", miss_count, 16'h0);
        @(posedge Clk);
        #1;
        mem_valid = 1'b1;
        mem_data = model_line(16'h0050);
        tick();
        mem_valid = 1'b0;
        @(negedge Clk);
        chk("stale_valid_ignored", mem_read, 1'b0);
        @(posedge Clk);
        #1;
        fetch(16'h0050, 2, 1'b1);

        // Hit counter wrap on a resident line.
        cpu_read = 1'b1;
        cpu_address = 16'h0052;
        while (exp_hits != 16'hFFFF) begin
            @(posedge Clk);
            exp_hits = exp_hits + 16'd1;
        end
        #1;
        @(negedge Clk);
        chk("wrap_ready", cpu_ready, 1'b1);
        chk("wrap_data", cpu_data, model_word(16'h0052));
        chk("hits_at_max", hit_count, 16'hFFFF);
        @(posedge Clk);
        #1;
        cpu_read = 1'b0;
        chk("hits_wrapped", hit_count, 16'h0000);
        chk("wrap_misses", miss_count, exp_miss);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
